// File: rtl/instr_loader_if.sv
// Write-side bus of the instruction memory.
// master drives mem_addr/mem_data/mem_wren; slave is the memory port.
interface instr_loader_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              mem_wren;

  modport master (
    output mem_addr,
    output mem_data,
    output mem_wren
  );

  modport slave (
    input mem_addr,
    input mem_data,
    input mem_wren
  );
endinterface

// File: rtl/instr_loader.sv
// Instruction memory programming front end: one write per strobe,
// consecutive addresses from 0, CPU held in reset while loading.
// Ports: clk, resetn (async, active-low), load_mode, strobe, data_in,
//   mem (write bus, master), cpu_hold, prog_len, full, checksum.
// Optional: define LOADER_CHECKSUM_EN for the running 8-bit checksum.
module instr_loader #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              load_mode,
  input  logic              strobe,
  input  logic [DATA_W-1:0] data_in,
  instr_loader_if.master    mem,
  output logic              cpu_hold,
  output logic [ADDR_W-1:0] prog_len,
  output logic              full,
  output logic [7:0]        checksum
);

  localparam logic [ADDR_W:0] LP_DEPTH =
    (ADDR_W+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_RUN,
    S_ARMED,
    S_WRITE,
    S_DRAIN
  } state_t;

  state_t r_state;
  state_t w_nxt;

  logic r_lm_s1;
  logic r_lm_s2;
  logic r_stb_s1;
  logic r_stb_s2;
  logic r_stb_s3;

  logic [ADDR_W:0]   r_wptr;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic              r_wren;
  logic              r_hold;
  logic [ADDR_W-1:0] r_len;
  logic              r_full;

  logic            w_lm;
  logic            w_rise;
  logic            w_arm_entry;
  logic            w_capture;
  logic            w_wr_exit;
  logic            w_hold_nxt;
  logic            w_wren_nxt;
  logic [ADDR_W:0] w_wptr_inc;
  logic [ADDR_W:0] w_wptr_nxt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_lm_s1  <= 1'b0;
      r_lm_s2  <= 1'b0;
      r_stb_s1 <= 1'b0;
      r_stb_s2 <= 1'b0;
      r_stb_s3 <= 1'b0;
    end else begin
      r_lm_s1  <= load_mode;
      r_lm_s2  <= r_lm_s1;
      r_stb_s1 <= strobe;
      r_stb_s2 <= r_stb_s1;
      r_stb_s3 <= r_stb_s2;
    end
  end

  assign w_lm   = r_lm_s2;
  assign w_rise = r_stb_s2 & ~r_stb_s3;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_RUN;
    else         r_state <= w_nxt;
  end

  // Dropping load_mode beats a coincident rise.
  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      S_RUN:   if (w_lm) w_nxt = S_ARMED;
      S_ARMED: begin
        if (!w_lm)
          w_nxt = S_DRAIN;
        else if (w_rise && !r_full)
          w_nxt = S_WRITE;
      end
      S_WRITE: w_nxt = S_ARMED;
      S_DRAIN: w_nxt = S_RUN;
      default: w_nxt = S_RUN;
    endcase
  end

  // Outputs are registered from the next state so
  // they line up with the state they describe.
  always_comb begin
    w_arm_entry = (r_state == S_RUN) &&
                  (w_nxt == S_ARMED);
    w_capture   = (r_state == S_ARMED) &&
                  (w_nxt == S_WRITE);
    w_wr_exit   = (r_state == S_WRITE);
    w_hold_nxt  = (w_nxt != S_RUN);
    w_wren_nxt  = (w_nxt == S_WRITE);
    w_wptr_inc  = (r_wptr == LP_DEPTH) ?
                  r_wptr : r_wptr + 1'b1;
    w_wptr_nxt  = r_wptr;
    if (w_arm_entry)
      w_wptr_nxt = '0;
    else if (w_wr_exit)
      w_wptr_nxt = w_wptr_inc;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wptr <= '0;
      r_addr <= '0;
      r_data <= '0;
      r_wren <= 1'b0;
      r_hold <= 1'b0;
      r_len  <= '0;
      r_full <= 1'b0;
    end else begin
      r_wptr <= w_wptr_nxt;
      r_wren <= w_wren_nxt;
      r_hold <= w_hold_nxt;
      r_full <= (w_wptr_nxt == LP_DEPTH);
      if (w_capture) begin
        r_addr <= r_wptr[ADDR_W-1:0];
        r_data <= data_in;
      end
      if (w_arm_entry)
        r_len <= '0;
      else if (w_wr_exit)
        r_len <= w_wptr_inc[ADDR_W-1:0];
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] r_csum;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      r_csum <= 8'h00;
    else if (w_arm_entry)
      r_csum <= 8'h00;
    else if (w_wr_exit)
      r_csum <= r_csum + 8'(r_data);
  end

  assign checksum = r_csum;
`else
  assign checksum = 8'h00;
`endif

  assign mem.mem_addr = r_addr;
  assign mem.mem_data = r_data;
  assign mem.mem_wren = r_wren;
  assign cpu_hold     = r_hold;
  assign prog_len     = r_len;
  assign full         = r_full;

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: main instance (DEPTH=256)
// and a DEPTH=4 instance share all stimulus.
module tb_instr_loader;

`ifdef LOADER_CHECKSUM_EN
  localparam bit CSUM_ON = 1'b1;
`else
  localparam bit CSUM_ON = 1'b0;
`endif

  logic       clk;
  logic       resetn;
  logic       load_mode;
  logic       strobe;
  logic [7:0] data_in;

  logic        hold0, full0;
  logic [15:0] len0;
  logic [7:0]  cs0;
  logic        hold1, full1;
  logic [15:0] len1;
  logic [7:0]  cs1;

  instr_loader_if #(.ADDR_W(16), .DATA_W(8)) m0 ();
  instr_loader_if #(.ADDR_W(16), .DATA_W(8)) m1 ();

  instr_loader #(.ADDR_W(16), .DATA_W(8), .DEPTH(256)) dut0 (
    .clk(clk), .resetn(resetn), .load_mode(load_mode),
    .strobe(strobe), .data_in(data_in), .mem(m0),
    .cpu_hold(hold0), .prog_len(len0), .full(full0),
    .checksum(cs0)
  );

  instr_loader #(.ADDR_W(16), .DATA_W(8), .DEPTH(4)) dut1 (
    .clk(clk), .resetn(resetn), .load_mode(load_mode),
    .strobe(strobe), .data_in(data_in), .mem(m1),
    .cpu_hold(hold1), .prog_len(len1), .full(full1),
    .checksum(cs1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vec = 0;
  int bad = 0;

  int          n0 = 0;
  int          n1 = 0;
  logic [15:0] a0 [64];
  logic [7:0]  d0 [64];
  logic [15:0] a1 [64];
  logic [7:0]  d1 [64];

  always @(negedge clk) begin
    if (m0.mem_wren === 1'b1 && n0 < 64) begin
      a0[n0] = m0.mem_addr;
      d0[n0] = m0.mem_data;
      n0++;
    end
    if (m1.mem_wren === 1'b1 && n1 < 64) begin
      a1[n1] = m1.mem_addr;
      d1[n1] = m1.mem_data;
      n1++;
    end
  end

  task automatic do_strobe(input logic [7:0] d);
    @(negedge clk);
    data_in = d;
    strobe  = 1'b1;
    repeat (3) @(negedge clk);
    strobe = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic enter_session();
    @(negedge clk);
    load_mode = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic exit_session();
    @(negedge clk);
    load_mode = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_reset();
    resetn    = 1'b0;
    load_mode = 1'b0;
    strobe    = 1'b0;
    data_in   = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    vec++;
    if ({m0.mem_wren, hold0, full0} !== 3'b000) begin
      bad++;
      $display("FAIL reset_flags got=%b want=000",
               {m0.mem_wren, hold0, full0});
    end
    vec++;
    if ({m0.mem_addr, m0.mem_data, len0, cs0} !== 48'h0) begin
      bad++;
      $display("FAIL reset_vals got=%h want=0",
               {m0.mem_addr, m0.mem_data, len0, cs0});
    end
    @(negedge clk);
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    vec++;
    if (hold0 !== 1'b0) begin
      bad++;
      $display("FAIL run_idle_hold got=%b want=0", hold0);
    end
  endtask

  task automatic test_basic();
    int base;
    logic [7:0] dv [3];
    dv[0] = 8'h13;
    dv[1] = 8'h27;
    dv[2] = 8'h31;
    base = n0;
    enter_session();
    vec++;
    if (hold0 !== 1'b1) begin
      bad++;
      $display("FAIL basic_hold got=%b want=1", hold0);
    end
    for (int i = 0; i < 3; i++) do_strobe(dv[i]);
    vec++;
    if (n0 - base !== 3) begin
      bad++;
      $display("FAIL basic_count got=%0d want=3", n0 - base);
    end
    for (int i = 0; i < 3; i++) begin
      vec++;
      if (a0[base+i] !== 16'(i) || d0[base+i] !== dv[i]) begin
        bad++;
        $display("FAIL basic_wr%0d got=%h/%h want=%h/%h", i,
                 a0[base+i], d0[base+i], 16'(i), dv[i]);
      end
    end
    vec++;
    if (len0 !== 16'd3) begin
      bad++;
      $display("FAIL basic_len got=%0d want=3", len0);
    end
    vec++;
    if (cs0 !== (CSUM_ON ? 8'h6B : 8'h00)) begin
      bad++;
      $display("FAIL basic_csum got=%h want=%h", cs0,
               CSUM_ON ? 8'h6B : 8'h00);
    end
    @(negedge clk);
    load_mode = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #1;
    vec++;
    if (hold0 !== 1'b1) begin
      bad++;
      $display("FAIL release_k2 got=%b want=1", hold0);
    end
    @(posedge clk);
    #1;
    vec++;
    if (hold0 !== 1'b0) begin
      bad++;
      $display("FAIL release_k3 got=%b want=0", hold0);
    end
    vec++;
    if (cs0 !== (CSUM_ON ? 8'h6B : 8'h00)) begin
      bad++;
      $display("FAIL csum_in_run got=%h", cs0);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reentry();
    int base;
    base = n0;
    enter_session();
    vec++;
    if (len0 !== 16'd0 || cs0 !== 8'h00) begin
      bad++;
      $display("FAIL reentry_clear got=%0d/%h want=0/00",
               len0, cs0);
    end
    do_strobe(8'h55);
    vec++;
    if (n0 - base !== 1 || a0[base] !== 16'd0 ||
        d0[base] !== 8'h55) begin
      bad++;
      $display("FAIL reentry_wr got=%0d %h/%h want=1 0/55",
               n0 - base, a0[base], d0[base]);
    end
    vec++;
    if (cs0 !== (CSUM_ON ? 8'h55 : 8'h00)) begin
      bad++;
      $display("FAIL reentry_csum got=%h", cs0);
    end
  endtask

  task automatic test_latency();
    int base;
    base = n0;
    @(negedge clk);
    data_in = 8'h9C;
    strobe  = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    vec++;
    if (m0.mem_wren !== 1'b0) begin
      bad++;
      $display("FAIL lat_k1 got=%b want=0", m0.mem_wren);
    end
    @(posedge clk);
    #1;
    vec++;
    if (m0.mem_wren !== 1'b1 || m0.mem_addr !== 16'd1 ||
        m0.mem_data !== 8'h9C) begin
      bad++;
      $display("FAIL lat_k2 got=%b %h/%h want=1 1/9c",
               m0.mem_wren, m0.mem_addr, m0.mem_data);
    end
    @(posedge clk);
    #1;
    vec++;
    if (m0.mem_wren !== 1'b0 || len0 !== 16'd2) begin
      bad++;
      $display("FAIL lat_k3 got=%b/%0d want=0/2",
               m0.mem_wren, len0);
    end
    repeat (17) @(negedge clk);
    strobe = 1'b0;
    repeat (3) @(negedge clk);
    vec++;
    if (n0 - base !== 1) begin
      bad++;
      $display("FAIL lat_held got=%0d want=1", n0 - base);
    end
    exit_session();
  endtask

  task automatic test_full();
    int base;
    base = n1;
    enter_session();
    for (int i = 0; i < 3; i++) do_strobe(8'(8'h40 + i));
    vec++;
    if (full1 !== 1'b0) begin
      bad++;
      $display("FAIL full_early got=%b want=0", full1);
    end
    do_strobe(8'h43);
    vec++;
    if (full1 !== 1'b1 || len1 !== 16'd4) begin
      bad++;
      $display("FAIL full_set got=%b/%0d want=1/4",
               full1, len1);
    end
    do_strobe(8'h44);
    do_strobe(8'h45);
    vec++;
    if (n1 - base !== 4 || len1 !== 16'd4) begin
      bad++;
      $display("FAIL full_count got=%0d/%0d want=4/4",
               n1 - base, len1);
    end
    for (int i = 0; i < 4; i++) begin
      vec++;
      if (a1[base+i] !== 16'(i) ||
          d1[base+i] !== 8'(8'h40 + i)) begin
        bad++;
        $display("FAIL full_wr%0d got=%h/%h", i,
                 a1[base+i], d1[base+i]);
      end
    end
    vec++;
    if (len0 !== 16'd6 || full0 !== 1'b0) begin
      bad++;
      $display("FAIL big_len got=%0d/%b want=6/0",
               len0, full0);
    end
    exit_session();
  endtask

  task automatic test_collision();
    int base;
    enter_session();
    do_strobe(8'h11);
    do_strobe(8'h22);
    base = n0;
    @(negedge clk);
    load_mode = 1'b0;
    strobe    = 1'b1;
    data_in   = 8'h77;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #1;
    vec++;
    if (hold0 !== 1'b1 || m0.mem_wren !== 1'b0) begin
      bad++;
      $display("FAIL coll_drain got=%b/%b want=1/0",
               hold0, m0.mem_wren);
    end
    @(posedge clk);
    #1;
    vec++;
    if (hold0 !== 1'b0) begin
      bad++;
      $display("FAIL coll_run got=%b want=0", hold0);
    end
    repeat (5) @(negedge clk);
    strobe = 1'b0;
    vec++;
    if (n0 - base !== 0 || len0 !== 16'd2) begin
      bad++;
      $display("FAIL coll_nowr got=%0d/%0d want=0/2",
               n0 - base, len0);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_midwrite();
    bit seen;
    seen = 1'b0;
    enter_session();
    @(negedge clk);
    data_in = 8'hA5;
    strobe  = 1'b1;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (m0.mem_wren === 1'b1) seen = 1'b1;
    end
    vec++;
    if (!seen) begin
      bad++;
      $display("FAIL mid_wait got=timeout want=wren");
    end
    #2;
    resetn    = 1'b0;
    load_mode = 1'b0;
    strobe    = 1'b0;
    #1;
    vec++;
    if (m0.mem_wren !== 1'b0 || hold0 !== 1'b0) begin
      bad++;
      $display("FAIL mid_abort got=%b/%b want=0/0",
               m0.mem_wren, hold0);
    end
    vec++;
    if ({m0.mem_addr, m0.mem_data, len0, cs0,
         full1} !== 49'h0) begin
      bad++;
      $display("FAIL mid_vals got=%h want=0",
               {m0.mem_addr, m0.mem_data, len0, cs0, full1});
    end
    @(negedge clk);
    resetn = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_reentry();
    test_latency();
    test_full();
    test_collision();
    test_reset_midwrite();
    $display("== %0d vectors applied, %0d miscompares ==",
             vec, bad);
    $finish;
  end

endmodule
